// File: rtl/wb_eic_pkg.sv
// Shared constants for the Wishbone external interrupt controller: register map,
// channel trigger modes and the VECTOR word layout.
package wb_eic_pkg;

  localparam logic [2:0] ADDR_IDR    = 3'd0;
  localparam logic [2:0] ADDR_IER    = 3'd1;
  localparam logic [2:0] ADDR_IMR    = 3'd2;
  localparam logic [2:0] ADDR_ISR    = 3'd3;
  localparam logic [2:0] ADDR_MODE0  = 3'd4;
  localparam logic [2:0] ADDR_MODE1  = 3'd5;
  localparam logic [2:0] ADDR_VECTOR = 3'd6;

  typedef logic [1:0] irq_mode_t;

  localparam irq_mode_t MODE_RISE = 2'b00;
  localparam irq_mode_t MODE_FALL = 2'b01;
  localparam irq_mode_t MODE_HIGH = 2'b10;
  localparam irq_mode_t MODE_LOW  = 2'b11;

  localparam int VEC_VALID_BIT = 31;

  // Scanning downwards lets the lowest pending channel overwrite any higher one.
  function automatic logic [31:0] vector_word(input logic [31:0] pend);
    logic [31:0] v;
    v = '0;
    for (int i = 31; i >= 0; i--) begin
      if (pend[i]) begin
        v                = '0;
        v[VEC_VALID_BIT] = 1'b1;
        v[4:0]           = 5'(i);
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/eic_channel.sv
// One interrupt channel: optional two-flop synchroniser, edge history,
// trigger-mode select and the latched ISR bit.
module eic_channel
  import wb_eic_pkg::*;
#(
  parameter int G_SYNC_INPUTS = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      irq,
  input  irq_mode_t mode,
  input  logic      enable,
  input  logic      clr,
  output logic      isr
);

  logic synced;
  logic prev;
  logic hit;

  generate
    if (G_SYNC_INPUTS != 0) begin : g_sync
      logic meta;
      always_ff @(posedge clk) begin
        if (rst) begin
          meta   <= 1'b0;
          synced <= 1'b0;
        end else begin
          meta   <= irq;
          synced <= meta;
        end
      end
    end else begin : g_direct
      assign synced = irq;
    end
  endgenerate

  // Edge history runs in every mode so a mode switch never sees a stale sample.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= synced;
  end

  always_comb begin
    hit = 1'b0;
    case (mode)
      MODE_RISE: hit = synced & ~prev;
      MODE_FALL: hit = ~synced & prev;
      MODE_HIGH: hit = synced;
      default:   hit = ~synced;
    endcase
  end

  // A fresh event wins over a same-cycle software clear.
  always_ff @(posedge clk) begin
    if (rst)               isr <= 1'b0;
    else if (enable & hit) isr <= 1'b1;
    else if (clr)          isr <= 1'b0;
  end

endmodule

// File: rtl/wb_eic_multi.sv
// Wishbone interrupt controller top: register file, bus handshake, vector
// encoder and the per-channel instances.
module wb_eic_multi
  import wb_eic_pkg::*;
#(
  parameter int G_NUM_IRQS    = 8,
  parameter int G_SYNC_INPUTS = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  rst_i,
  input  logic [2:0]            wb_addr_i,
  input  logic [31:0]           wb_data_i,
  output logic [31:0]           wb_data_o,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  output logic                  wb_ack_o,
  input  logic [G_NUM_IRQS-1:0] irq_i,
  output logic                  wb_irq_o
);

  localparam logic [63:0] MODE_MASK = (64'd1 << (2 * G_NUM_IRQS)) - 64'd1;

  logic                  access;
  logic                  wr_en;
  logic [G_NUM_IRQS-1:0] imr;
  logic [G_NUM_IRQS-1:0] isr;
  logic [G_NUM_IRQS-1:0] isr_clr;
  logic [G_NUM_IRQS-1:0] wr_bits;
  logic [G_NUM_IRQS-1:0] pending;
  logic [63:0]           mode_all;
  logic [31:0]           rd_data;
  logic [31:0]           vector;
  logic                  unused_sel;

  // Masking ack out of access forces an idle cycle between back-to-back strobes.
  assign access     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_en      = access & wb_we_i;
  assign wr_bits    = wb_data_i[G_NUM_IRQS-1:0];
  assign isr_clr    = (wr_en && wb_addr_i == ADDR_ISR) ? wr_bits : '0;
  assign pending    = isr & imr;
  assign vector     = vector_word(32'(pending));
  assign unused_sel = ^{wb_sel_i, wb_data_i};

  always_comb begin
    rd_data = '0;
    case (wb_addr_i)
      ADDR_IMR:    rd_data = 32'(imr);
      ADDR_ISR:    rd_data = 32'(isr);
      ADDR_MODE0:  rd_data = mode_all[31:0];
      ADDR_MODE1:  rd_data = mode_all[63:32];
      ADDR_VECTOR: rd_data = vector;
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      wb_ack_o  <= 1'b0;
      wb_data_o <= '0;
      wb_irq_o  <= 1'b0;
      imr       <= '0;
      mode_all  <= '0;
    end else begin
      wb_ack_o <= access;
      wb_irq_o <= |pending;
      if (access) wb_data_o <= rd_data;
      if (wr_en) begin
        case (wb_addr_i)
          ADDR_IDR:   imr <= imr & ~wr_bits;
          ADDR_IER:   imr <= imr | wr_bits;
          ADDR_MODE0: mode_all[31:0]  <= wb_data_i & MODE_MASK[31:0];
          ADDR_MODE1: mode_all[63:32] <= wb_data_i & MODE_MASK[63:32];
          default:    ;
        endcase
      end
    end
  end

  generate
    for (genvar n = 0; n < G_NUM_IRQS; n++) begin : g_ch
      eic_channel #(
        .G_SYNC_INPUTS(G_SYNC_INPUTS)
      ) u_ch (
        .clk   (wb_clk_i),
        .rst   (rst_i),
        .irq   (irq_i[n]),
        .mode  (mode_all[2*n +: 2]),
        .enable(imr[n]),
        .clr   (isr_clr[n]),
        .isr   (isr[n])
      );
    end
  endgenerate

endmodule
